// File: rtl/seq_alu.sv
// seq_alu: sequenced 16-bit ALU feeding the zero-flag register.
// Single-cycle logic/add/sub/shift ops; 16-cycle iterative shift-add multiply.
// Build option: define SEQ_ALU_MUL_EN to compile in the MUL opcode and MUL
// state. When it is undefined, opcode 111 completes in one cycle as an illegal
// op: it leaves ALU_out untouched and does not pulse Zero_flag_enable.
module seq_alu #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ALU_out,
    output logic              Zero_flag_enable,
    output logic              illegal_op
);

    logic [DATA_W-1:0] alu_q, alu_d;
    logic              done_q, done_d;
    logic              zfe_q, zfe_d;
    logic [DATA_W-1:0] simple_res;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_sum;
`else
    logic              ill_q, ill_d;
`endif

    // Single-cycle result for the currently presented opcode and operands
    always_comb begin
        simple_res = '0;
        case (opcode)
            3'b000:  simple_res = A + B;
            3'b001:  simple_res = A - B;
            3'b010:  simple_res = A & B;
            3'b011:  simple_res = A | B;
            3'b100:  simple_res = A ^ B;
            3'b101:  simple_res = A << B[3:0];
            3'b110:  simple_res = A >> B[3:0];
            default: simple_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // Accumulator value after this iteration's conditional add
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and datapath control for IDLE/MUL
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        alu_d    = alu_q;
        done_d   = 1'b0;
        zfe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opcode == 3'b111) begin
                        state_d  = S_MUL;
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        alu_d  = simple_res;
                        done_d = 1'b1;
                        zfe_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                // 16th iteration publishes the sum including its final add
                if (cnt_q == 4'd15) begin
                    alu_d   = acc_sum;
                    done_d  = 1'b1;
                    zfe_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            alu_q    <= '0;
            done_q   <= 1'b0;
            zfe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            alu_q    <= alu_d;
            done_q   <= done_d;
            zfe_q    <= zfe_d;
        end
    end

    assign busy       = (state_q == S_MUL);
    assign illegal_op = 1'b0;
`else
    // Single-state control: every accepted op completes in one cycle
    always_comb begin
        alu_d  = alu_q;
        done_d = 1'b0;
        zfe_d  = 1'b0;
        ill_d  = 1'b0;
        if (start) begin
            done_d = 1'b1;
            if (opcode == 3'b111) begin
                ill_d = 1'b1;
            end else begin
                alu_d = simple_res;
                zfe_d = 1'b1;
            end
        end
    end

    // Output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_q  <= '0;
            done_q <= 1'b0;
            zfe_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            done_q <= done_d;
            zfe_q  <= zfe_d;
            ill_q  <= ill_d;
        end
    end

    assign busy       = 1'b0;
    assign illegal_op = ill_q;
`endif

    assign ALU_out          = alu_q;
    assign done             = done_q;
    assign Zero_flag_enable = zfe_q;

endmodule
